// File: rtl/mon_pkg.sv
// Shared types for the commit monitor: retirement record layout and error causes.
package mon_pkg;

  localparam int MON_ORDER_W = 64;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_ORDER     = 2'd2,
    ERR_POST_HALT = 2'd3
  } mon_err_e;

  typedef struct packed {
    logic [MON_ORDER_W-1:0] order;
    logic [31:0]            inst;
    logic                   halt;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [31:0]            rs1_rdata;
    logic [31:0]            rs2_rdata;
    logic [4:0]             rd_addr;
    logic [31:0]            rd_wdata;
    logic [31:0]            pc_rdata;
    logic [31:0]            pc_wdata;
    logic [31:0]            mem_addr;
    logic [3:0]             mem_rmask;
    logic [3:0]             mem_wmask;
    logic [31:0]            mem_rdata;
    logic [31:0]            mem_wdata;
  } mon_pkt_t;

endpackage

// File: rtl/mon_lane_compactor.sv
// Packs the valid commit lanes into consecutive slots in lane-index order and
// locates the lowest-index halting lane. Purely combinational.
module mon_lane_compactor
  import mon_pkg::*;
#(
  parameter int  CHANNELS = 8,
  localparam int NW       = $clog2(CHANNELS + 1),
  localparam int LW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic     [CHANNELS-1:0] in_valid,
  input  mon_pkt_t [CHANNELS-1:0] in_pkt,
  output mon_pkt_t [CHANNELS-1:0] cmp_pkt,
  output logic     [NW-1:0]       n,
  output logic                    halt_any,
  output logic     [LW-1:0]       halt_lane
);

  logic [NW-1:0] pos [CHANNELS];
  logic [NW-1:0] acc;

  // Slot of each lane is the number of valid lanes below it; slot j takes the lane whose slot is j.
  always_comb begin
    acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos[i] = acc;
      acc    = acc + NW'(in_valid[i]);
    end
    n = acc;

    cmp_pkt = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_valid[i] && (pos[i] == NW'(j))) cmp_pkt[j] = in_pkt[i];
      end
    end

    halt_any  = 1'b0;
    halt_lane = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i] && in_pkt[i].halt) begin
        halt_any  = 1'b1;
        halt_lane = LW'(i);
      end
    end
  end

endmodule

// File: rtl/mon_commit_serializer.sv
// Multi-lane retirement records in, one record per cycle out through a FIFO,
// with commit-order, post-halt and overflow checking and a sticky first error.
module mon_commit_serializer
  import mon_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 32,
  parameter int ORDER_W  = MON_ORDER_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic     [CHANNELS-1:0]      in_valid,
  input  mon_pkt_t [CHANNELS-1:0]      in_pkt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output mon_pkt_t                     out_pkt,
  output logic     [$clog2(DEPTH+1)-1:0] count,
  output logic                         halted,
  output logic                         error,
  output mon_err_e                     error_code
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int NW   = $clog2(CHANNELS + 1);
  localparam int LW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  mon_pkt_t                mem [DEPTH];
  logic     [PW-1:0]       head, tail;
  logic     [ORDER_W-1:0]  expected;
  logic                    halt_seen;

  mon_pkt_t [CHANNELS-1:0] cmp_pkt;
  logic     [NW-1:0]       n;
  logic                    halt_any;
  logic     [LW-1:0]       halt_lane;

  logic     [CNTW-1:0]     space;
  logic                    push_ok, pop, order_bad, late_lane, post_halt, err_hit;
  mon_err_e                err_cause;

  mon_lane_compactor #(.CHANNELS(CHANNELS)) u_compactor (
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .cmp_pkt   (cmp_pkt),
    .n         (n),
    .halt_any  (halt_any),
    .halt_lane (halt_lane)
  );

  assign out_valid = (count != '0);
  assign out_pkt   = mem[head];

  // Admission, order/halt checks and first-error cause; room is judged before this cycle's pop.
  always_comb begin
    space     = CNTW'(DEPTH) - count;
    push_ok   = (CNTW'(n) <= space);
    pop       = out_valid && out_ready;
    order_bad = 1'b0;
    late_lane = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if ((NW'(k) < n) && (cmp_pkt[k].order != expected + ORDER_W'(k))) order_bad = 1'b1;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_valid[i] && halt_any && (LW'(i) > halt_lane)) late_lane = 1'b1;
    end
    post_halt = (halt_seen && (n != '0)) || late_lane;
    err_hit   = 1'b0;
    err_cause = ERR_NONE;
    if (!push_ok) begin
      err_hit   = 1'b1;
      err_cause = ERR_OVERFLOW;
    end else if (order_bad) begin
      err_hit   = 1'b1;
      err_cause = ERR_ORDER;
    end else if (post_halt) begin
      err_hit   = 1'b1;
      err_cause = ERR_POST_HALT;
    end
  end

  // Record storage: compacted slots land at tail, tail+1, ... wrapping through the buffer.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push_ok && (NW'(k) < n)) mem[tail + PW'(k)] <= cmp_pkt[k];
    end
  end

  // Pointers, occupancy, order tracking, halt flags and the sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      expected   <= '0;
      halt_seen  <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
    end else begin
      if (push_ok) begin
        tail     <= tail + PW'(n);
        expected <= expected + ORDER_W'(n);
        if (halt_any) halt_seen <= 1'b1;
      end
      if (pop) begin
        head <= head + PW'(1);
        if (out_pkt.halt) halted <= 1'b1;
      end
      count <= count + (push_ok ? CNTW'(n) : '0) - CNTW'(pop);
      if (!error && err_hit) begin
        error      <= 1'b1;
        error_code <= err_cause;
      end
    end
  end

endmodule

// File: tb/tb_mon_commit_serializer.sv
// Randomized bench for mon_commit_serializer against a queue-based reference model.
module tb_mon_commit_serializer;
  import mon_pkg::*;

  localparam int CH = 8;
  localparam int DP = 32;
  localparam int CW = $clog2(DP + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic     [CH-1:0]       in_valid;
  mon_pkt_t [CH-1:0]       in_pkt;
  logic                    out_valid;
  logic                    out_ready;
  mon_pkt_t                out_pkt;
  logic     [CW-1:0]       count;
  logic                    halted;
  logic                    error;
  mon_err_e                error_code;

  always #5 clk = ~clk;

  mon_commit_serializer #(.CHANNELS(CH), .DEPTH(DP), .ORDER_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pkt     (in_pkt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pkt    (out_pkt),
    .count      (count),
    .halted     (halted),
    .error      (error),
    .error_code (error_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  mon_pkt_t    mq[$];
  logic [63:0] m_exp;
  bit          m_hs, m_halted, m_err;
  mon_err_e    m_code;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mon_pkt_t rand_pkt(input logic [63:0] ord, input bit h);
    mon_pkt_t p;
    p.order     = ord;
    p.inst      = $urandom;
    p.halt      = h;
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = $urandom;
    p.pc_wdata  = $urandom;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  // Valid lanes carry consecutive orders from the model's expected value; idle lanes carry junk.
  task automatic set_in(input logic [CH-1:0] mask, input int hl);
    int k;
    k = 0;
    for (int i = 0; i < CH; i++) begin
      if (mask[i]) begin
        in_pkt[i] = rand_pkt(m_exp + 64'(k), (i == hl));
        k++;
      end else begin
        in_pkt[i] = rand_pkt(64'($urandom), 1'($urandom));
      end
    end
    in_valid = mask;
  endtask

  // Advance model and DUT one clock, then compare every observable.
  task automatic tick();
    bit       pop, ord_bad, ph, hs_now;
    int       n, free, k;
    mon_pkt_t acc[$];
    pop = out_ready && (mq.size() != 0);
    if (!rst) begin
      mq.delete();
      m_exp = '0; m_hs = 0; m_halted = 0; m_err = 0; m_code = ERR_NONE;
    end else begin
      n    = $countones(in_valid);
      free = DP - mq.size();
      if (n > free) begin
        if (!m_err) begin m_err = 1; m_code = ERR_OVERFLOW; end
      end else begin
        k = 0; ord_bad = 0; ph = 0; hs_now = 0;
        for (int i = 0; i < CH; i++) begin
          if (in_valid[i]) begin
            if (in_pkt[i].order != m_exp + 64'(k)) ord_bad = 1;
            if (m_hs || hs_now) ph = 1;
            if (in_pkt[i].halt) hs_now = 1;
            acc.push_back(in_pkt[i]);
            k++;
          end
        end
        if (!m_err && ord_bad) begin m_err = 1; m_code = ERR_ORDER; end
        else if (!m_err && ph) begin m_err = 1; m_code = ERR_POST_HALT; end
        m_exp = m_exp + 64'(n);
        m_hs  = m_hs | hs_now;
      end
      if (pop) begin
        if (mq[0].halt) m_halted = 1;
        void'(mq.pop_front());
      end
      foreach (acc[j]) mq.push_back(acc[j]);
    end
    @(posedge clk);
    #1;
    check("count", count, mq.size());
    check("out_valid", out_valid, (mq.size() != 0));
    if (mq.size() != 0) check("out_pkt", out_pkt, mq[0]);
    check("error", error, m_err);
    check("error_code", error_code, m_code);
    check("halted", halted, m_halted);
  endtask

  task automatic do_reset();
    in_valid = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = '0; in_pkt = '0; out_ready = 1'b0;
    m_exp = '0; m_hs = 0; m_halted = 0; m_err = 0; m_code = ERR_NONE;

    // Reset then idle
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();

    // Sparse lanes 0,2,5,7 compacted and popped in lane order
    out_ready = 1'b1;
    set_in(8'b1010_0101, -1); tick();
    in_valid = '0;
    repeat (6) tick();

    // Reset mid-stream with five buffered records
    out_ready = 1'b0;
    set_in(8'b0001_1111, -1); tick();
    in_valid = '0; out_ready = 1'b1; rst = 1'b0; tick();
    rst = 1'b1; tick();

    // Fill to 28, overflow with 8, drain partly, then a push that wraps the tail
    out_ready = 1'b0;
    repeat (7) begin set_in(8'h0F, -1); tick(); end
    set_in(8'hFF, -1); tick();
    in_valid = '0; tick();
    out_ready = 1'b1;
    repeat (10) tick();
    set_in(8'hF0, -1); tick();
    set_in(8'h3C, -1); tick();
    in_valid = '0;
    repeat (30) tick();

    // Order gap 0,1,3 latches ERR_ORDER; a later overflow keeps that cause
    do_reset();
    out_ready = 1'b0;
    set_in(8'h07, -1);
    in_pkt[2].order = 64'd3;
    tick();
    repeat (8) begin set_in(8'hF0, -1); tick(); end
    in_valid = '0; out_ready = 1'b1;
    repeat (34) tick();

    // Halt on lane 2 with lane 3 also valid; halted rises when lane 2's record pops
    do_reset();
    out_ready = 1'b0;
    set_in(8'h0F, 2); tick();
    in_valid = '0; out_ready = 1'b1;
    repeat (6) tick();

    // Commit in the cycle after a halt
    do_reset();
    set_in(8'h01, 0); tick();
    set_in(8'h02, -1); tick();
    in_valid = '0;
    repeat (3) tick();

    // Single-lane pushes with out_ready toggling every cycle
    do_reset();
    for (int c = 0; c < 200; c++) begin
      out_ready = c[0];
      if ($urandom_range(0, 3) != 0) set_in(CH'(1) << $urandom_range(0, CH - 1), -1);
      else in_valid = '0;
      tick();
    end

    // Random multi-lane traffic with random back-pressure
    do_reset();
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) set_in(CH'($urandom) & CH'($urandom), -1);
      else in_valid = '0;
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
